// File: rtl/game_state_ctl.sv
// Screen sequencer START -> LEVEL_1 -> FINISH, switching only on frame boundaries.
// Optional LEVEL_1 timeout enabled by defining GAME_TIMEOUT_EN.
package game_state_pkg;
    typedef enum logic [1:0] {
        START   = 2'd0,
        LEVEL_1 = 2'd1,
        FINISH  = 2'd2
    } g_state;
endpackage

module game_state_ctl
    import game_state_pkg::*;
#(
    parameter int unsigned FINISH_FRAMES = 180,
    parameter int unsigned LEVEL_FRAMES  = 3600
) (
    input  logic   clk_40,
    input  logic   rst_n,
    input  logic   vblnk,
    input  logic   mouse_left,
    input  logic   p1_at_exit,
    input  logic   p2_at_exit,
    output g_state game_state,
    output logic   level_init,
    output logic   won
);

    localparam int unsigned MAX_FRAMES = (FINISH_FRAMES > LEVEL_FRAMES) ? FINISH_FRAMES : LEVEL_FRAMES;
    localparam int unsigned CNT_W      = (MAX_FRAMES > 2) ? $clog2(MAX_FRAMES) : 1;
    localparam logic [CNT_W-1:0] FIN_LAST = CNT_W'(FINISH_FRAMES - 1);
`ifdef GAME_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LVL_LAST = CNT_W'(LEVEL_FRAMES - 1);
`endif

    logic             vblnk_q;
    logic             mouse_q;
    logic             armed;
    logic             frame_tick;
    logic             click;
    logic             click_pend;
    logic             pend_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    g_state           state_nxt;
    logic             init_nxt;
    logic             won_nxt;

    // armed blocks a level already high at reset release from looking like an edge
    assign frame_tick = armed & vblnk & ~vblnk_q;
    assign click      = armed & mouse_left & ~mouse_q;
    assign cnt_inc    = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk_40 or negedge rst_n) begin
        if (!rst_n) begin
            game_state <= START;
            level_init <= 1'b0;
            won        <= 1'b0;
            cnt        <= '0;
            click_pend <= 1'b0;
            vblnk_q    <= 1'b0;
            mouse_q    <= 1'b0;
            armed      <= 1'b0;
        end else begin
            game_state <= state_nxt;
            level_init <= init_nxt;
            won        <= won_nxt;
            cnt        <= cnt_nxt;
            click_pend <= pend_nxt;
            vblnk_q    <= vblnk;
            mouse_q    <= mouse_left;
            armed      <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = game_state;
        init_nxt  = 1'b0;
        won_nxt   = won;
        cnt_nxt   = cnt;
        pend_nxt  = click_pend;

        case (game_state)
            START: begin
                if (frame_tick && click_pend) begin
                    state_nxt = LEVEL_1;
                    init_nxt  = 1'b1;
                    won_nxt   = 1'b0;
                end
            end
            LEVEL_1: begin
                if (frame_tick) begin
                    if (p1_at_exit && p2_at_exit) begin
                        state_nxt = FINISH;
                        won_nxt   = 1'b1;
                    end
`ifdef GAME_TIMEOUT_EN
                    else if (cnt == LVL_LAST) begin
                        state_nxt = FINISH;
                        won_nxt   = 1'b0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
`endif
                end
            end
            FINISH: begin
                if (frame_tick) begin
                    if (cnt == FIN_LAST || click_pend) begin
                        state_nxt = START;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: state_nxt = START;
        endcase

        if (state_nxt != game_state) begin
            cnt_nxt = '0;
        end

        // a click coinciding with a tick or screen change survives for the next tick
        if (game_state == LEVEL_1 || state_nxt == LEVEL_1) begin
            pend_nxt = 1'b0;
        end else if (click) begin
            pend_nxt = 1'b1;
        end else if (frame_tick || state_nxt != game_state) begin
            pend_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_game_state_ctl.sv
// Self-checking bench for game_state_ctl: vector table, directed corner sequences,
// and randomized stimulus against a frame-level reference model.
`timescale 1ns/1ps
module tb_game_state_ctl;
    import game_state_pkg::*;

    localparam int unsigned FIN = 4;
    localparam int unsigned LVL = 5;

    logic   clk_40 = 1'b0;
    logic   rst_n  = 1'b0;
    logic   vblnk = 1'b0, mouse_left = 1'b0, p1_at_exit = 1'b0, p2_at_exit = 1'b0;
    g_state game_state;
    logic   level_init, won;

    game_state_ctl #(.FINISH_FRAMES(FIN), .LEVEL_FRAMES(LVL)) dut (
        .clk_40(clk_40), .rst_n(rst_n), .vblnk(vblnk), .mouse_left(mouse_left),
        .p1_at_exit(p1_at_exit), .p2_at_exit(p2_at_exit),
        .game_state(game_state), .level_init(level_init), .won(won)
    );

    always #5 clk_40 = ~clk_40;

    int n_pass = 0, n_total = 0;

    // Reference model: tracks screen, ticks seen since entering it, and pending click
    g_state m_state;
    bit     m_init, m_won, m_pend, m_vb_prev, m_ml_prev, m_armed;
    int     m_ticks;

    task automatic model_reset();
        m_state = START; m_init = 0; m_won = 0; m_pend = 0;
        m_vb_prev = 0; m_ml_prev = 0; m_armed = 0; m_ticks = 0;
    endtask

    task automatic model_step(input bit vb, input bit ml, input bit p1, input bit p2);
        bit     tick, press;
        g_state nxt;
        tick  = m_armed && vb && !m_vb_prev;
        press = m_armed && ml && !m_ml_prev;
        m_vb_prev = vb; m_ml_prev = ml; m_armed = 1;
        nxt    = m_state;
        m_init = 0;
        if (tick) begin
            m_ticks++;
            if (m_state == START) begin
                if (m_pend) begin nxt = LEVEL_1; m_init = 1; m_won = 0; end
            end else if (m_state == LEVEL_1) begin
                if (p1 && p2) begin nxt = FINISH; m_won = 1; end
`ifdef GAME_TIMEOUT_EN
                else if (m_ticks == LVL) begin nxt = FINISH; m_won = 0; end
`endif
            end else begin
                if (m_ticks == FIN || m_pend) nxt = START;
            end
        end
        if (m_state == LEVEL_1 || nxt == LEVEL_1) m_pend = 0;
        else if (press) m_pend = 1;
        else if (tick) m_pend = 0;
        if (nxt != m_state) m_ticks = 0;
        m_state = nxt;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic check_out(input string nm, input g_state st, input bit init, input bit w);
        chk({nm, ".state"}, int'(game_state), int'(st));
        chk({nm, ".level_init"}, int'(level_init), int'(init));
        chk({nm, ".won"}, int'(won), int'(w));
    endtask

    task automatic check_model(input string nm);
        check_out(nm, m_state, m_init, m_won);
    endtask

    task automatic cyc(input bit vb, input bit ml, input bit p1, input bit p2);
        @(negedge clk_40);
        vblnk = vb; mouse_left = ml; p1_at_exit = p1; p2_at_exit = p2;
        model_step(vb, ml, p1, p2);
        @(posedge clk_40); #1;
    endtask

    task automatic do_reset(input bit vb, input bit ml);
        @(negedge clk_40);
        vblnk = vb; mouse_left = ml; p1_at_exit = 0; p2_at_exit = 0;
        #1 rst_n = 0;
        #1 check_out("async_reset", START, 0, 0);
        model_reset();
        repeat (2) @(negedge clk_40);
        rst_n = 1;
        model_step(vb, ml, 0, 0);
        @(posedge clk_40); #1;
    endtask

    // one frame: tick cycle, then a cycle that may carry a click, then idle
    task automatic frame(input bit clk_after, input bit p1, input bit p2);
        cyc(1, 0, p1, p2);
        cyc(0, clk_after, p1, p2);
        cyc(0, 0, p1, p2);
    endtask

    task automatic enter_level();
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        check_out("enter_level", LEVEL_1, 1, 0);
        cyc(0, 0, 0, 0);
        check_out("level_init_once", LEVEL_1, 0, 0);
    endtask

    typedef struct {
        bit vb, ml, p1, p2;
        g_state st;
        bit init, w;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit vb, ml, p1, p2;
        int nb;

        tbl[0]  = '{0,0,0,0, START,   0,0};
        tbl[1]  = '{1,0,0,0, START,   0,0};
        tbl[2]  = '{0,1,0,0, START,   0,0};
        tbl[3]  = '{0,1,0,0, START,   0,0};
        tbl[4]  = '{1,0,0,0, LEVEL_1, 1,0};
        tbl[5]  = '{0,0,0,0, LEVEL_1, 0,0};
        tbl[6]  = '{1,1,1,0, LEVEL_1, 0,0};
        tbl[7]  = '{0,0,1,1, LEVEL_1, 0,0};
        tbl[8]  = '{1,0,1,1, FINISH,  0,1};
        tbl[9]  = '{0,0,0,0, FINISH,  0,1};
        tbl[10] = '{1,0,0,0, FINISH,  0,1};
        tbl[11] = '{0,1,0,0, FINISH,  0,1};
        tbl[12] = '{0,0,0,0, FINISH,  0,1};
        tbl[13] = '{1,0,0,0, START,   0,1};
        tbl[14] = '{0,0,0,0, START,   0,1};
        tbl[15] = '{1,0,0,0, START,   0,1};

        model_reset();
        #1 check_out("reset_state", START, 0, 0);
        do_reset(0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].vb, tbl[i].ml, tbl[i].p1, tbl[i].p2);
            check_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].init, tbl[i].w);
        end

        // click coinciding with a tick counts only for the following tick
        do_reset(0, 0);
        cyc(1, 1, 0, 0);
        check_out("click_on_tick", START, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check_out("click_on_tick_next", LEVEL_1, 1, 0);

        // one exit only keeps the level running; both exits finish it
        do_reset(0, 0);
        enter_level();
`ifdef GAME_TIMEOUT_EN
        nb = 3;
`else
        nb = 10;
`endif
        for (int i = 0; i < nb; i++) begin
            frame(0, 1, 0);
            check_out("one_exit", LEVEL_1, 0, 0);
        end
        cyc(1, 0, 1, 1);
        check_out("both_exit", FINISH, 0, 1);
        cyc(0, 0, 0, 0);

        // FINISH hold without click: return on 4th tick
        for (int t = 1; t <= 4; t++) begin
            cyc(1, 0, 0, 0);
            check_out($sformatf("finish_hold_t%0d", t), (t < 4) ? FINISH : START, 0, 1);
            cyc(0, 0, 0, 0);
        end

        // re-entry clears won; click after tick 1 returns on tick 2
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        check_out("reenter", LEVEL_1, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 1);
        check_out("win2", FINISH, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check_out("finish_t1", FINISH, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check_out("finish_click_t2", START, 0, 1);

        // level time limit behaviour
        do_reset(0, 0);
        enter_level();
        for (int t = 1; t <= 5; t++) begin
            cyc(1, 0, 0, 0);
`ifdef GAME_TIMEOUT_EN
            check_out($sformatf("timeout_t%0d", t), (t < 5) ? LEVEL_1 : FINISH, 0, 0);
`else
            check_out($sformatf("no_timeout_t%0d", t), LEVEL_1, 0, 0);
`endif
            cyc(0, 0, 0, 0);
        end
`ifdef GAME_TIMEOUT_EN
        do_reset(0, 0);
        enter_level();
        for (int t = 1; t <= 4; t++) frame(0, 0, 0);
        cyc(1, 0, 1, 1);
        check_out("win_beats_timeout", FINISH, 0, 1);
`endif

        // clicks ignored in level; reset mid-level with button and vblank held
        do_reset(0, 0);
        enter_level();
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        check_out("level_click_ignored", LEVEL_1, 0, 0);
        cyc(0, 1, 0, 0);
        do_reset(1, 1);
        check_out("release_held", START, 0, 0);
        cyc(1, 1, 0, 0);
        check_out("held_no_tick", START, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check_out("held_no_click", START, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check_out("fresh_click", LEVEL_1, 1, 0);

        // randomized run against the reference model
        do_reset(0, 0);
        vb = 0; ml = 0; p1 = 0; p2 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) vb = ~vb;
            if ($urandom_range(0, 9) == 0) ml = ~ml;
            if ($urandom_range(0, 7) == 0) p1 = ~p1;
            if ($urandom_range(0, 7) == 0) p2 = ~p2;
            if ($urandom_range(0, 599) == 0) begin
                do_reset(vb, ml);
                check_model("rand_reset");
            end
            cyc(vb, ml, p1, p2);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_state_ctl.md
GAME_STATE_CTL -- requirements
Module: game_state_ctl

Interface
REQ-001 The block SHALL have parameter FINISH_FRAMES, default 180; frame ticks the FINISH screen is held before auto-return to START.
REQ-002 The block SHALL have parameter LEVEL_FRAMES, default 3600; LEVEL_1 time limit in frame ticks, used only with the Configuration macro.
REQ-003 The block SHALL have port clk_40  input  1  40 MHz pixel clock, sole clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port vblnk  input  1  vertical blank from VGA timing, synchronous to clk_40.
REQ-006 The block SHALL have port mouse_left  input  1  left mouse button level, synchronous to clk_40.
REQ-007 The block SHALL have port p1_at_exit  input  1  player 1 inside exit zone.
REQ-008 The block SHALL have port p2_at_exit  input  1  player 2 inside exit zone.
REQ-009 The block SHALL have port game_state  output  g_state  current screen select for the VGA mux: START, LEVEL_1 or FINISH.
REQ-010 The block SHALL have port level_init  output  1  one-cycle pulse; reload player and rectangle start positions.
REQ-011 The block SHALL have port won  output  1  result of last level: 1 = both players exited, 0 = timeout.

Function
REQ-012 The block SHALL derive frame_tick as a one-cycle pulse on each 0->1 edge of vblnk, using a registered copy of vblnk.
REQ-013 The block SHALL derive click as a one-cycle pulse on each 0->1 edge of mouse_left, using a registered copy of mouse_left.
REQ-014 The block SHALL latch a click into a sticky click_pend flag, cleared only by a frame_tick or a state change.
REQ-015 The block SHALL change game_state only in the cycle after a frame_tick, so screens never switch mid-frame.
REQ-016 START: on frame_tick with click_pend=1, the block SHALL go to LEVEL_1, pulse level_init for exactly one cycle in that same cycle, and clear the frame counter.
REQ-017 LEVEL_1: on frame_tick with p1_at_exit=1 and p2_at_exit=1, the block SHALL go to FINISH and set won=1.
REQ-018 FINISH: the block SHALL count frame ticks in a frame counter wide enough for max(FINISH_FRAMES, LEVEL_FRAMES), saturating at its maximum.
REQ-019 FINISH: on frame_tick, the block SHALL go to START when the counter equals FINISH_FRAMES-1 or click_pend=1, whichever occurs first.
REQ-020 The block SHALL clear the frame counter on every state change.
REQ-021 The block SHALL hold won from entry into FINISH until the next entry into LEVEL_1, where it clears to 0.
REQ-022 The block SHALL ignore clicks that arrive in LEVEL_1 and SHALL NOT retain them as pending.
REQ-023 The block SHALL latch a click arriving in the same cycle as a frame_tick as pending for the next tick, not the current one.
REQ-024 The block SHALL treat any game_state encoding other than START, LEVEL_1 or FINISH as START on the next clock.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force game_state=START, level_init=0, won=0, frame counter=0, click_pend=0, and both edge-detect registers=0.
REQ-026 An assertion of rst_n mid-frame or mid-level SHALL abort immediately; after release the block SHALL require a fresh click before entering LEVEL_1.
REQ-027 The block SHALL resume edge detection on the first clk_40 edge after rst_n deasserts; a vblnk or mouse_left already high at release SHALL NOT produce a tick or click.

Configuration
REQ-028 With macro GAME_TIMEOUT_EN defined, the block SHALL count frame ticks in LEVEL_1 and go to FINISH with won=0 on the frame_tick where the counter equals LEVEL_FRAMES-1.
REQ-029 With GAME_TIMEOUT_EN defined, if win and timeout occur on the same frame_tick, the win SHALL take priority and won=1.
REQ-030 Without GAME_TIMEOUT_EN, the block SHALL leave LEVEL_1 only on a win, and won SHALL be 1 whenever game_state=FINISH.

Verification
REQ-031 Reset, click mid-frame, next vblnk rise -> game_state=LEVEL_1 exactly one cycle after the tick; level_init high for exactly 1 cycle.
REQ-032 LEVEL_1, p1_at_exit=1 and p2_at_exit=0 for 10 frames -> stays LEVEL_1; then p2_at_exit=1 -> FINISH, won=1.
REQ-033 FINISH_FRAMES=4, no click -> returns to START on the 4th frame tick after entry; with a click after tick 1 -> returns to START on tick 2.
REQ-034 GAME_TIMEOUT_EN defined, LEVEL_FRAMES=5, no exits -> FINISH with won=0 on the 5th tick; exits and timeout on the same tick -> won=1.
REQ-035 Clicks in LEVEL_1; rst_n pulsed low mid-level with mouse_left held high -> START, no pending click, no LEVEL_1 entry until mouse_left is released and pressed again.
